muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Sequential successor to the single-cycle combinational ALU.
- Executes MIPS MULT/MULTU/DIV/DIVU over multiple cycles under a start/busy/done handshake.
- Also supports direct HI/LO writes (MTHI/MTLO).
- Sits beside the main ALU in the execute stage; HI/LO are read continuously for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Optional zero-operand early-out path enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       dbg_state_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   // Handshake: start is sampled only in IDLE; busy is high from the cycle after
   // start until the result lands; done pulses for one cycle with hi/lo updated.
   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mq_q, mq_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               div_q, div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     shifted;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_comb begin
      a_neg    = ~op[0] & a[WIDTH-1];
      b_neg    = ~op[0] & b[WIDTH-1];
      mag_a    = a_neg ? -a : a;
      mag_b    = b_neg ? -b : b;
      mul_sum  = {1'b0, acc_q} + {1'b0, dvs_q};
      shifted  = {acc_q, mq_q[WIDTH-1]};
      prod     = {acc_q, mq_q};
      prod_fix = neg_q ? -prod : prod;
      quo_fix  = neg_q ? -mq_q : mq_q;
      rem_fix  = rneg_q ? -acc_q : acc_q;

      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      dvs_d   = dvs_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      zero_d  = zero_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = '0;
               acc_d   = '0;
               mq_d    = mag_a;
               dvs_d   = mag_b;
               div_d   = op[1];
               neg_d   = a_neg ^ b_neg;
               rneg_d  = a_neg;
               zero_d  = op[1] & (b == '0);
               dbz_d   = 1'b0;
               state_d = RUN;
`ifdef MULDIV_EARLY_OUT_EN
               // Preload the accumulator so FIN's sign fix yields hi = a for x/0.
               if ((a == '0) || (b == '0)) begin
                  state_d = FIN;
                  mq_d    = '0;
                  acc_d   = (op[1] && (b == '0)) ? mag_a : '0;
               end
`endif
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         RUN: begin
            if (div_q) begin
               // Restoring step; remainder always fits WIDTH bits, so subtract mod 2^WIDTH.
               if (shifted >= {1'b0, dvs_q}) begin
                  acc_d = shifted[WIDTH-1:0] - dvs_q;
                  mq_d  = {mq_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = shifted[WIDTH-1:0];
                  mq_d  = {mq_q[WIDTH-2:0], 1'b0};
               end
            end else if (mq_q[0]) begin
               {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
            end else begin
               {acc_d, mq_d} = {1'b0, acc_q, mq_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
         end
         FIN: begin
            if (div_q) begin
               hi_d  = rem_fix;
               lo_d  = zero_q ? '1 : quo_fix;
               dbz_d = zero_q;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         dvs_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         zero_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         dvs_q   <= dvs_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         zero_q  <= zero_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH = 32).
// Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_muldiv_unit;

   localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = W + 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b, wdata;
   logic         hi_we, lo_we;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;
   logic [1:0]   dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo),
      .dbg_state_o (dbg_state)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents start for exactly one edge (edge 0), then scrambles the operands.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      op    = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done(input int already, output int lat);
      lat = already;
      while (lat < 100) begin
         tick();
         lat++;
         if (done) break;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dbz, input int exp_lat);
      int lat;
      issue(o, x, y);
      check_eq($sformatf("%s_busy_run", tag), busy, 1'b1);
      check_eq($sformatf("%s_dbz_clr", tag), div_by_zero, 1'b0);
      wait_done(0, lat);
      check_eq($sformatf("%s_lat", tag), lat, exp_lat);
      check_eq($sformatf("%s_hi", tag), hi, exp_hi);
      check_eq($sformatf("%s_lo", tag), lo, exp_lo);
      check_eq($sformatf("%s_dbz", tag), div_by_zero, exp_dbz);
      check_eq($sformatf("%s_busy_done", tag), busy, 1'b0);
      tick();
      check_eq($sformatf("%s_done_pulse", tag), done, 1'b0);
      check_eq($sformatf("%s_hold_lo", tag), lo, exp_lo);
   endtask

   initial begin
      int lat;
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = '0;
      repeat (3) tick();
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_dbz", div_by_zero, 1'b0);
      check_eq("rst_hi", hi, '0);
      check_eq("rst_lo", lo, '0);
      check_eq("rst_state", dbg_state, 2'd0);
      rst = 1'b0;
      tick();

      //       tag          op     a             b             hi            lo            dbz   latency
      run_op("mult_neg",   2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, W + 1);
      run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, W + 1);
      run_op("mult_m1m1",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, W + 1);
      run_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, W + 1);
      run_op("multu_2p32", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, W + 1);
      run_op("div_n7_2",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W + 1);
      run_op("divu_100_7", 2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, W + 1);
      run_op("divu_by0",   2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, EARLY_LAT);
      run_op("div_7_n2",   2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, W + 1);
      run_op("div_n7_n2",  2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, W + 1);
      run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, W + 1);
      run_op("divu_max_1", 2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, W + 1);
      run_op("div_neg_by0",2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, EARLY_LAT);
      run_op("mult_zero",  2'b00, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0, EARLY_LAT);
      run_op("div_zero_a", 2'b10, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, EARLY_LAT);

      // Start and MTHI while busy are both dropped.
      issue(2'b01, 32'd6, 32'd7);
      repeat (4) tick();
      start = 1'b1;
      op    = 2'b00;
      a     = 32'd9;
      b     = 32'd9;
      hi_we = 1'b1;
      wdata = 32'hDEADBEEF;
      tick();
      start = 1'b0;
      hi_we = 1'b0;
      check_eq("intf_busy", busy, 1'b1);
      wait_done(5, lat);
      check_eq("intf_lat", lat, W + 1);
      check_eq("intf_hi", hi, 32'd0);
      check_eq("intf_lo", lo, 32'd42);
      tick();

      hi_we = 1'b1;
      wdata = 32'hA5A5A5A5;
      tick();
      hi_we = 1'b0;
      check_eq("mthi_hi", hi, 32'hA5A5A5A5);
      check_eq("mthi_lo", lo, 32'd42);
      lo_we = 1'b1;
      wdata = 32'h5A5A5A5A;
      tick();
      lo_we = 1'b0;
      check_eq("mtlo_lo", lo, 32'h5A5A5A5A);
      check_eq("mtlo_hi", hi, 32'hA5A5A5A5);
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'h0F0F0F0F;
      tick();
      hi_we = 1'b0;
      lo_we = 1'b0;
      check_eq("mtboth_hi", hi, 32'h0F0F0F0F);
      check_eq("mtboth_lo", lo, 32'h0F0F0F0F);

      // Writes presented together with start are dropped.
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hFFFFFFFF;
      issue(2'b01, 32'd3, 32'd4);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check_eq("wstart_hi", hi, 32'h0F0F0F0F);
      check_eq("wstart_lo", lo, 32'h0F0F0F0F);
      wait_done(0, lat);
      check_eq("wstart_lat", lat, W + 1);
      check_eq("wstart_res_lo", lo, 32'd12);
      check_eq("wstart_res_hi", hi, 32'd0);
      tick();

      // Asynchronous reset mid-divide.
      hi_we = 1'b1;
      wdata = 32'h11111111;
      tick();
      hi_we = 1'b0;
      issue(2'b11, 32'd100, 32'd7);
      repeat (10) tick();
      check_eq("prerst_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("midrst_busy", busy, 1'b0);
      check_eq("midrst_done", done, 1'b0);
      check_eq("midrst_hi", hi, 32'd0);
      check_eq("midrst_lo", lo, 32'd0);
      check_eq("midrst_state", dbg_state, 2'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check_eq("postrst_busy", busy, 1'b0);
      check_eq("postrst_lo", lo, 32'd0);
      run_op("after_rst",  2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, W + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
